// File: rtl/cla20_acc_seq_pkg.sv
// Shared definitions for the frame accumulator and other users of the cla20d add/sub cell.
// Holds the state encoding, default widths and signed-overflow detection.
package cla20_acc_seq_pkg;

    localparam int WIDTH_DEF = 19;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Two's-complement overflow from the sign bits of A, B and the truncated sum S.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic s_msb, input logic sub);
        if (sub)
            return (a_msb != b_msb) && (s_msb != a_msb);
        else
            return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla20_acc_seq_if.sv
// Operand and result streams of the frame accumulator, both valid/ready.
// The master side is the producer/consumer environment, the slave side is the accumulator.
interface cla20_acc_seq_if
    import cla20_acc_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   in_data;
    logic             in_sub;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_sub, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_sub, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/cla20_acc_seq_cla20d.sv
// cla20d: carry-lookahead add/sub cell, out = a + b (in=0) or a - b (in=1).
// 4-bit lookahead groups chained group to group; out carries one extra carry bit on top.
module cla20d #(
    parameter int WIDTH = 19
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH:0]   b,
    input  logic             in,
    output logic [WIDTH+1:0] out
);
    localparam int N  = WIDTH + 1;
    localparam int NG = (N + 3) / 4;
    localparam int NP = NG * 4;

    logic [NP-1:0] g;
    logic [NP-1:0] p;
    logic [NP:0]   c;

    // Subtraction as a + ~b + 1; padded upper bits neither generate nor propagate.
    assign g = NP'(a & (b ^ {N{in}}));
    assign p = NP'(a ^ (b ^ {N{in}}));

    always_comb begin
        // NOTE: every bit of c gets a default before the loop so no path leaves it unassigned and
        // infers a latch.
        c    = '0;
        c[0] = in;
        for (int gi = 0; gi < NG; gi++) begin
            c[4*gi+1] = g[4*gi] | (p[4*gi] & c[4*gi]);
            c[4*gi+2] = g[4*gi+1] | (p[4*gi+1] & g[4*gi])
                      | (p[4*gi+1] & p[4*gi] & c[4*gi]);
            c[4*gi+3] = g[4*gi+2] | (p[4*gi+2] & g[4*gi+1])
                      | (p[4*gi+2] & p[4*gi+1] & g[4*gi])
                      | (p[4*gi+2] & p[4*gi+1] & p[4*gi] & c[4*gi]);
            c[4*gi+4] = (g[4*gi+3] | (p[4*gi+3] & g[4*gi+2])
                      | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                      | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]))
                      | (&p[4*gi +: 4] & c[4*gi]);
        end
    end

    assign out = {c[N], p[N-1:0] ^ c[N-1:0]};
endmodule

// File: rtl/cla20_acc_seq.sv
// Frame accumulator: adds/subtracts each accepted operand into a running sum and presents
// sum, saturating beat count and sticky signed overflow when the frame's last beat arrives.
module cla20_acc_seq
    import cla20_acc_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    cla20_acc_seq_if.slave  bus
);
    state_t           state;
    logic [WIDTH:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [WIDTH:0]   sum;
    logic             carry_unused;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             accept;

    cla20d #(.WIDTH(WIDTH)) u_cla (
        .a   (acc),
        .b   (bus.in_data),
        .in  (bus.in_sub),
        .out ({carry_unused, sum})
    );

    assign accept  = bus.in_valid & bus.in_ready;
    assign cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
    assign ovf_nxt = ovf | add_ovf(acc[WIDTH], bus.in_data[WIDTH], sum[WIDTH], bus.in_sub);

    // in_ready and out_valid are registered copies of the state so no input reaches an output
    // combinationally.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
        if (rst) begin
            state         <= ACC;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_count <= '0;
            bus.out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        acc <= sum;
                        cnt <= cnt_nxt;
                        ovf <= ovf_nxt;
                        if (bus.in_last) begin
                            bus.out_data  <= sum;
                            bus.out_count <= cnt_nxt;
                            bus.out_ovf   <= ovf_nxt;
                            bus.out_valid <= 1'b1;
                            bus.in_ready  <= 1'b0;
                            state         <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        acc           <= '0;
                        cnt           <= '0;
                        ovf           <= 1'b0;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_cla20_acc_seq.sv
// Bench for cla20_acc_seq: integer reference model compared every cycle, plus directed frames
// with hand-computed results and a randomized frame/handshake phase.
module tb_cla20_acc_seq;
    localparam int W     = 20;
    localparam int CNTW  = 8;
    localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   cmp_en   = 1'b0;
    bit   rnd_mode = 1'b0;

    cla20_acc_seq_if #(.WIDTH(W - 1), .CNT_W(CNTW)) bus ();

    cla20_acc_seq #(.WIDTH(W - 1), .CNT_W(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: signed integer sums, explicit range test for overflow.
    bit              m_hold;
    logic [W-1:0]    m_acc;
    int              m_cnt;
    bit              m_ovf;
    logic [W-1:0]    m_out_data;
    int              m_out_cnt;
    bit              m_out_ovf;

    always @(posedge clk) begin
        longint sa, sd, t;
        if (rst) begin
            m_hold = 0; m_acc = '0; m_cnt = 0; m_ovf = 0;
            m_out_data = '0; m_out_cnt = 0; m_out_ovf = 0;
        end else if (!m_hold) begin
            if (bus.in_valid) begin
                sa = longint'($signed(m_acc));
                sd = longint'($signed(bus.in_data));
                t  = bus.in_sub ? sa - sd : sa + sd;
                if (t > MAXV || t < MINV) m_ovf = 1;
                m_acc = t[W-1:0];
                if (m_cnt < (1 << CNTW) - 1) m_cnt = m_cnt + 1;
                if (bus.in_last) begin
                    m_out_data = m_acc; m_out_cnt = m_cnt; m_out_ovf = m_ovf;
                    m_hold = 1;
                end
            end
        end else if (bus.out_ready) begin
            m_hold = 0; m_acc = '0; m_cnt = 0; m_ovf = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready",  32'(bus.in_ready),  32'(!m_hold));
            check("out_valid", 32'(bus.out_valid), 32'(m_hold));
            check("out_data",  32'(bus.out_data),  32'(m_out_data));
            check("out_count", 32'(bus.out_count), 32'(m_out_cnt));
            check("out_ovf",   32'(bus.out_ovf),   32'(m_out_ovf));
        end
    end

    // Presents one beat from posedge+1 and keeps it until the block takes it.
    task automatic send(input logic [W-1:0] d, input logic s, input logic l);
        bit done = 0;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_sub = s; bus.in_last = l;
        for (int i = 0; i < 400 && !done; i++) begin
            if (rnd_mode) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk); #1;
        end
        check("send_accepted", 32'(done), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [W-1:0] d,
                                 input int c, input logic o);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        check({name, "_valid"}, 32'(seen), 32'd1);
        check({name, "_data"},  32'(bus.out_data),  32'(d));
        check({name, "_count"}, 32'(bus.out_count), 32'(c));
        check({name, "_ovf"},   32'(bus.out_ovf),   32'(o));
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_data = '0; bus.in_sub = 0; bus.in_last = 0; bus.out_ready = 0;
        @(posedge clk); #1;
        cmp_en = 1;
        @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // Back-to-back 5 + 3 - 2; result visible at the very next negedge.
        send(20'd5, 0, 0);
        send(20'd3, 0, 0);
        send(20'd2, 1, 1);
        @(negedge clk);
        check("t1_latency", 32'(bus.out_valid), 32'd1);
        expect_result("t1", 20'h00006, 3, 0);
        take();

        send(20'd1, 1, 1);
        expect_result("t2a", 20'hFFFFF, 1, 0);
        take();
        send(20'h12345, 0, 1);
        expect_result("t2b", 20'h12345, 1, 0);
        take();

        send(20'h7FFFF, 0, 0);
        send(20'd1, 0, 0);
        send(20'd1, 1, 1);
        expect_result("t3_sticky", 20'h7FFFF, 3, 1);
        take();

        send(20'h80000, 1, 1);
        expect_result("t_negmin", 20'h80000, 1, 1);

        // Result left pending while a new beat waits upstream; out_ready in ACC is a no-op.
        bus.in_valid = 1; bus.in_data = 20'd9; bus.in_sub = 0; bus.in_last = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_in_ready",  32'(bus.in_ready),  32'd0);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_out_data",  32'(bus.out_data),  32'h80000);
        end
        bus.out_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("hs_out_valid", 32'(bus.out_valid), 32'd0);
        check("hs_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
        bus.in_valid = 0; bus.out_ready = 0;
        expect_result("hs_next", 20'd9, 1, 0);
        take();

        for (int i = 0; i < 300; i++) send(20'd1, 0, logic'(i == 299));
        expect_result("t_sat", 20'h0012C, 255, 0);
        take();

        send(20'd7, 0, 0);
        send(20'd7, 0, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        send(20'd4, 0, 1);
        expect_result("t_rst_mid", 20'h00004, 1, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rst_hold_valid", 32'(bus.out_valid), 32'd0);
        check("rst_hold_ready", 32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
        rst = 0;

        rnd_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int nb;
            nb = $urandom_range(1, 8);
            for (int b = 0; b < nb; b++) begin
                logic [W-1:0] d;
                d = W'($urandom);
                if ($urandom_range(0, 3) == 0) d = {d[W-1], {(W-1){~d[W-1]}}};
                repeat ($urandom_range(0, 2)) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                send(d, 1'($urandom_range(0, 1)), logic'(b == nb - 1));
            end
        end
        rnd_mode = 0;
        bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cla20_acc_seq.md
Name: cla20_acc_seq

Overview:
- Frame-based sequential accumulator built around the team's 20-bit carry-lookahead add/sub cell.
- Accepts a stream of 20-bit two's-complement operands over a valid/ready handshake. Each operand carries its own add/sub flag.
- Each operand is added to or subtracted from a running accumulator. On the last beat of a frame, the result, operand count and sticky signed-overflow flag are presented on a valid/ready output port.
- Sits directly upstream of downstream consumers that need a per-frame sum; it drives the add/sub cell every accepted beat.

Parameters:
- WIDTH, 19, MSB index of data path (data is WIDTH+1 = 20 bits)
- CNT_W, 8, width of the per-frame operand counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts operand this cycle
- in_data  input  WIDTH+1  operand, two's complement
- in_sub  input  1  0: acc+in_data, 1: acc-in_data
- in_last  input  1  beat is last of frame
- out_valid  output  1  frame result valid
- out_ready  input  1  consumer takes result
- out_data  output  WIDTH+1  frame sum, wrap-around modulo 2^(WIDTH+1)
- out_count  output  CNT_W  operands in frame, saturating
- out_ovf  output  1  sticky signed overflow seen during frame

Behaviour:
- Reset is synchronous and active-high on rst; there is one clock, clk.
- Reset values:
  - state=ACC, acc=0, cnt=0, ovf=0
  - in_ready=1, out_valid=0, out_data=0, out_count=0, out_ovf=0
- State ACC:
  - in_ready=1, out_valid=0.
  - Beat accepted when in_valid & in_ready.
  - On an accepted beat:
    - acc <= acc ± in_data (adder A=acc, B=in_data, sub=in_sub).
    - cnt <= cnt+1, saturating at all-ones.
    - ovf <= ovf | beat_ovf.
  - beat_ovf for add: A[MSB]==B[MSB] and S[MSB]!=A[MSB].
  - beat_ovf for sub: A[MSB]!=B[MSB] and S[MSB]!=A[MSB].
  - Accepted beat with in_last=1: out_data/out_count/out_ovf load the post-beat values, state -> HOLD.
  - Latency: out_valid rises the cycle after the last beat is accepted.
- State HOLD:
  - in_ready=0, out_valid=1; out_* stable until handshake.
  - On out_valid & out_ready: acc=0, cnt=0, ovf=0, out_valid=0, state -> ACC.
  - No input is accepted in the handshake cycle; the first beat of the next frame can be accepted the following cycle. Peak throughput is one frame per (beats+1) cycles.
- Arithmetic:
  - Results are truncated to WIDTH+1 bits (wrap-around); there is no saturation of data.
  - The adder's extra MSB/carry output is ignored.
  - Overflow is reported only via out_ovf.
- Boundary conditions:
  - Single-beat frame (in_last on first beat): result = 0 ± in_data, count=1.
  - Subtract of the most-negative value from 0: result = 0x80000, ovf=1.
  - Counter saturates at 2^CNT_W-1 and holds; accumulation continues.
  - in_valid while in HOLD: ignored; the upstream holds its beat.
  - rst mid-frame or in HOLD: partial frame and any pending result are discarded; registers return to reset values the next cycle.
  - out_ready asserted in ACC: no effect.
- All outputs are driven from registers; there is no combinational path from in_* to out_*. in_ready depends on state only.

Decomposition:
- Shared package:
  - state encoding (ACC=1'b0, HOLD=1'b1)
  - default WIDTH/CNT_W constants
  - overflow-detect function shared with other adder users
- Sub-module: one instance of the existing 20-bit carry-lookahead add/sub cell cla20d (WIDTH=19), with A=acc, B=in_data, in=in_sub; its out feeds acc next-value.
- Control FSM and counters are inline in cla20_acc_seq.

Test Plan:
- Beats 5(add), 3(add), 2(sub, last) back-to-back -> out_valid one cycle after third beat; out_data=0x00006, out_count=3, out_ovf=0.
- Single beat 1(sub, last) -> out_data=0xFFFFF, count=1, ovf=0; then 0x12345(add, last) -> out_data=0x12345, count=1 (acc cleared between frames).
- Beats 0x7FFFF(add), 1(add), 1(sub, last) -> out_data=0x7FFFF, ovf=1 (sticky despite final value in range).
- Hold out_ready=0 for 3 cycles after result with in_valid=1 -> in_ready=0, out_* stable for all 3 cycles; out_ready=1 -> out_valid=0 next cycle, in_ready=1, next frame's first beat accepted one cycle later.
- 300 beats of 1(add), last on 300th -> out_data=0x0012C, out_count=255 (saturated).
- Beats 7,7 then rst=1 for one cycle mid-frame, then 4(add, last) -> out_data=0x00004, count=1, ovf=0; a rst asserted in HOLD drops out_valid the next cycle.
